// File: rtl/project1_ir_input_pkg.sv
// Shared definitions for the IR input PIO block.
//   - Avalon-MM word offsets of the four registers.
//   - Encodings of the EDGE_TYPE parameter.
//   - Debounce counter width (DEBOUNCE_CYCLES is limited to 1..255).
//   - edge_match(): per-bit edge qualifier used by the top level.
package project1_ir_input_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_IRQMASK = 2'd1;
  localparam logic [1:0] REG_RSVD    = 2'd2;
  localparam logic [1:0] REG_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int DEB_CNT_W = 8;

  // True when the transition prev -> cur is one the block is configured to capture.
  function automatic logic edge_match(input logic cur, input logic prev, input int edge_type);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_RISING:  return rise;
      EDGE_FALLING: return fall;
      default:      return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/project1_ir_input_debounce.sv
// Single-bit input conditioner: 2-flop synchronizer followed by a debounce
// counter.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   raw      asynchronous input bit (idle high)
//   level    debounced value of raw
//
// The counter measures how long the synchronized sample has disagreed with
// the debounced level. Any agreement restarts it at 0, so only a disagreement
// lasting DEBOUNCE_CYCLES consecutive samples moves the level.
module project1_ir_input_debounce
  import project1_ir_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 sync_meta;
  logic                 sync_out;
  logic [DEB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Idle-high reset so leaving reset with an idle input creates no edge.
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
      cnt       <= '0;
      level     <= 1'b1;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/project1_ir_input_pio.sv
// Avalon-MM PIO for active-low IR receiver inputs with per-bit debounce,
// edge capture and a maskable level interrupt.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   address       word offset: 0 DATA (RO), 1 IRQMASK (RW), 2 reserved,
//                 3 EDGECAP (read, write-1-to-clear)
//   chipselect    slave select (qualifies writes only)
//   write_n       active-low write strobe
//   writedata     write data, bits [WIDTH-1:0] used
//   in_port       asynchronous external inputs
//   readdata      registered read data, zero above WIDTH
//   irq           registered |(EDGECAP & IRQMASK)
//
// Bus handshake: there is no waitrequest. A write is accepted in every cycle
// where chipselect=1 and write_n=0 and takes effect at that clock edge.
// readdata is reloaded every cycle from the address mux, so the data for an
// address presented in cycle N is valid in cycle N+1; reads have no side
// effects.
module project1_ir_input_pio
  import project1_ir_input_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry register contents.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    project1_ir_input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (in_port[i]),
      .level   (level[i])
    );
  end

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && (address == REG_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_hit[i] = edge_match(level[i], level_d[i], EDGE_TYPE);
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      REG_DATA:    rd_word[WIDTH-1:0] = level;
      REG_IRQMASK: rd_word[WIDTH-1:0] = irqmask;
      REG_EDGECAP: rd_word[WIDTH-1:0] = edgecap;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d  <= '1;
      edgecap  <= '0;
      irqmask  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      level_d  <= level;
      // The set term is applied after the clear so a new edge wins.
      edgecap  <= (edgecap & ~cap_clr) | edge_hit;
      if (wr_en && (address == REG_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      irq      <= |(edgecap & irqmask);
      readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_project1_ir_input_pio.sv
// Bench for project1_ir_input_pio with default parameters
// (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 falling).
// Driver tasks are entered on a falling clock edge, drive the bus and
// in_port, and return on the next falling edge. Every bus cycle that is
// checked pushes {irq, readdata} expected one cycle later; the monitor pops
// and compares on the falling edge after the capturing rising edge.
module tb_project1_ir_input_pio;
  import project1_ir_input_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_valid = 1'b0;
  logic [32:0] mon_exp;
  string       mon_name;
  int          checks   = 0;
  int          failures = 0;

  project1_ir_input_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Read data appears one cycle after the address is presented.
  always @(posedge clk) rd_valid <= rd_issue;

  // ---------------- driver tasks ----------------
  function automatic logic [32:0] ex(input logic i, input logic [31:0] d);
    return {i, d};
  endfunction

  task automatic read_cycle(input logic [1:0] addr, input logic [32:0] exp, input string name);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    writedata  = 32'h0;
    rd_issue   = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // The register mux still drives readdata during a write, so the old
  // register value is checked along with the write.
  task automatic write_cycle(input logic [1:0] addr, input logic [31:0] data,
                             input logic [32:0] exp, input string name);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    rd_issue   = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_issue   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got irq=%0b readdata=%08h, required no pending entry",
                 irq, readdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if ({irq, readdata} !== mon_exp) begin
          failures++;
          $display("FAIL %s: got irq=%0b readdata=%08h, required irq=%0b readdata=%08h",
                   mon_name, irq, readdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'hFF;
    @(negedge clk);

    // Reset values, then idle register contents.
    repeat (2) read_cycle(REG_DATA, ex(1'b0, 32'h0), "reset_readdata");
    reset_n = 1'b1;
    read_cycle(REG_DATA,    ex(1'b0, 32'h000000FF), "idle_data");
    read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "idle_edgecap");
    read_cycle(REG_IRQMASK, ex(1'b0, 32'h0), "idle_irqmask");
    read_cycle(REG_RSVD,    ex(1'b0, 32'h0), "idle_rsvd");

    // 3-cycle glitch on bit0 is filtered.
    in_port = 8'hFE;
    repeat (3) read_cycle(REG_DATA, ex(1'b0, 32'hFF), "glitch_data_low");
    in_port = 8'hFF;
    repeat (8) read_cycle(REG_DATA, ex(1'b0, 32'hFF), "glitch_data_after");
    read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "glitch_edgecap");

    // Falling edge on bit0: EDGECAP set 7 edges after the fall, irq one later.
    write_cycle(REG_IRQMASK, 32'h1, ex(1'b0, 32'h0), "mask_wr");
    in_port = 8'hFE;
    repeat (7) read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "fall_wait");
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h1), "fall_cap_latency");
    repeat (2) read_cycle(REG_EDGECAP, ex(1'b1, 32'h1), "fall_cap_hold");
    read_cycle(REG_DATA, ex(1'b1, 32'hFE), "fall_data");
    write_cycle(REG_EDGECAP, 32'h1, ex(1'b1, 32'h1), "clr_wr");
    read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "clr_edgecap_irq");

    // Rising edge is not captured with falling-edge configuration.
    in_port = 8'hFF;
    repeat (9) read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "rise_nocap");
    read_cycle(REG_DATA, ex(1'b0, 32'hFF), "rise_data");

    // Two bits captured, clear only bit1.
    in_port = 8'hFC;
    idle_cycles(9);
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h3), "cap_both");
    write_cycle(REG_EDGECAP, 32'h2, ex(1'b1, 32'h3), "clr_bit1_wr");
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h1), "clr_bit1");

    // Bit1 edge lands on the same edge as its clear: edge wins.
    in_port = 8'hFF;
    idle_cycles(10);
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h1), "pre_race");
    in_port = 8'hFD;
    idle_cycles(6);
    write_cycle(REG_EDGECAP, 32'h2, ex(1'b1, 32'h1), "race_wr");
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h3), "race_edge_wins");

    // Mask path, mask readback, DATA write ignored.
    write_cycle(REG_IRQMASK, 32'h0, ex(1'b1, 32'h1), "mask_clr_wr");
    read_cycle(REG_IRQMASK, ex(1'b0, 32'h0), "mask_clr_irq_low");
    write_cycle(REG_IRQMASK, 32'hABCD_0082, ex(1'b0, 32'h0), "mask_wr2");
    read_cycle(REG_IRQMASK, ex(1'b1, 32'h82), "mask_rd2");
    write_cycle(REG_DATA, 32'h0, ex(1'b1, 32'hFD), "data_wr");
    read_cycle(REG_DATA, ex(1'b1, 32'hFD), "data_after_wr");

    // Reserved offset.
    write_cycle(REG_RSVD, 32'hFFFF_FFFF, ex(1'b1, 32'h0), "rsvd_wr");
    read_cycle(REG_RSVD, ex(1'b1, 32'h0), "rsvd_rd");
    read_cycle(REG_EDGECAP, ex(1'b1, 32'h3), "rsvd_no_effect");

    // Reset in the middle of a debounce count.
    in_port = 8'hFE;
    idle_cycles(4);
    reset_n = 1'b0;
    in_port = 8'hFF;
    repeat (3) read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "rst_hold");
    reset_n = 1'b1;
    repeat (10) read_cycle(REG_EDGECAP, ex(1'b0, 32'h0), "rst_no_edge");
    read_cycle(REG_DATA, ex(1'b0, 32'hFF), "rst_data");
    read_cycle(REG_IRQMASK, ex(1'b0, 32'h0), "rst_mask");

    idle_cycles(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/project1_ir_input_pio.md
PROJECT1_IR_INPUT_PIO -- requirements
Module: project1_ir_input_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive equal synchronized samples required before a bit's debounced value changes; range 1..255.
REQ-003 Parameter EDGE_TYPE, default 1: edge that sets capture; 0 rising, 1 falling, 2 any.
REQ-004 Clocking and reset: reset reset_n, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 address  input  2  Avalon-MM word offset.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  input  32  write data; bits [WIDTH-1:0] used.
REQ-011 in_port  input  WIDTH  asynchronous external inputs (IR receiver, active-low).
REQ-012 readdata  output  32  registered read data; bits above WIDTH always 0.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Register map: offset 0 DATA (RO, debounced value); offset 1 IRQMASK (RW); offset 2 reserved (reads 0, writes ignored); offset 3 EDGECAP (read; write-1-to-clear).
REQ-015 Each in_port bit passes through a 2-flop synchronizer; synchronized value lags in_port by 2 cycles.
REQ-016 Debounce: per-bit counter resets to 0 whenever synchronized sample equals debounced value; otherwise increments; when counter reaches DEBOUNCE_CYCLES-1 and sample still differs, debounced bit takes sample and counter clears next cycle.
REQ-017 Glitch shorter than DEBOUNCE_CYCLES cycles shall not change the debounced value nor set EDGECAP.
REQ-018 Edge detect on debounced value vs its one-cycle-delayed copy; qualifying edge per EDGE_TYPE sets EDGECAP bit on the next clock edge.
REQ-019 EDGECAP bit stays set until cleared by write to offset 3 with that writedata bit 1; writedata bits 0 leave bits unchanged.
REQ-020 Simultaneous edge and clear on same bit, same cycle: bit ends set (edge wins).
REQ-021 Write to offset 1 loads IRQMASK <= writedata[WIDTH-1:0] on the write cycle edge.
REQ-022 irq = |(EDGECAP & IRQMASK), registered; asserts 1 cycle after EDGECAP/IRQMASK change.
REQ-023 readdata registered every cycle from address mux (chipselect not required for read); read latency 1 cycle.
REQ-024 Writes to offset 0 ignored; reads have no side effects.

Reset
REQ-025 While reset_n low: synchronizers, debounced value, delayed copy set to all-ones (idle-high input), counters 0, EDGECAP 0, IRQMASK 0, readdata 0, irq 0.
REQ-026 Reset assertion mid-debounce abandons the count; deassertion produces no spurious edge when in_port is idle high.

Structure
REQ-027 Shared package holds register offset constants (DATA=0, IRQMASK=1, RSVD=2, EDGECAP=3) and EDGE_TYPE encodings.
REQ-028 One sub-module project1_ir_input_debounce (single bit: synchronizer, counter, debounced output), instantiated WIDTH times via generate.

Verification
REQ-029 Reset, idle in_port=8'hFF -> read offset 0 = 32'h000000FF, offset 3 = 0, irq = 0.
REQ-030 in_port bit0 low for 3 cycles then high (DEBOUNCE_CYCLES=4) -> DATA stays 8'hFF, EDGECAP stays 0.
REQ-031 IRQMASK=8'h01, bit0 held low 10 cycles -> EDGECAP=8'h01 at 2+4+1 cycles after fall, irq high one cycle later; write 8'h01 to offset 3 -> EDGECAP 0, irq low next cycle.
REQ-032 EDGECAP=8'h03, write 8'h02 to offset 3 -> EDGECAP=8'h01.
REQ-033 Bit1 edge lands same cycle as clear write 8'h02 -> EDGECAP bit1 remains 1.
REQ-034 Read offset 2 after writing 32'hFFFFFFFF to it -> readdata 0; reset_n pulsed low mid-debounce -> all registers at REQ-025 values, no irq.
